// File: rtl/riscv_decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | riscv_decode_stage                                                     |
// | RISC-V ID stage: regfile with WB bypass, immediate gen, control decode,|
// | load-use hazard detection and the ID/EX pipeline register.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module riscv_decode_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            ex_stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [2:0]      ex_imm_type,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_illegal
);

  localparam int         c_addr_w   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] c_num_regs = 6'(NUM_REGS);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_op     = 7'b0110011;

  localparam logic [2:0] c_imm_x  = 3'd0;
  localparam logic [2:0] c_imm_i  = 3'd1;
  localparam logic [2:0] c_imm_s  = 3'd2;
  localparam logic [2:0] c_imm_sb = 3'd3;
  localparam logic [2:0] c_imm_u  = 3'd4;
  localparam logic [2:0] c_imm_uj = 3'd5;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [2:0]      w_imm_type;
  logic            w_reg_write;
  logic            w_mem_read;
  logic            w_mem_write;
  logic            w_illegal;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_hazard;

  logic [XLEN-1:0] r_regs [NUM_REGS];

  assign w_opcode = if_inst[6:0];
  assign w_rd     = if_inst[11:7];
  assign w_rs1    = if_inst[19:15];
  assign w_rs2    = if_inst[24:20];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0) && ({1'b0, wb_rd} < c_num_regs)) begin
      r_regs[wb_rd[c_addr_w-1:0]] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0)
      return '0;
    else if (wb_we && (wb_rd == idx))
      return wb_data;
    else if ({1'b0, idx} < c_num_regs)
      return r_regs[idx[c_addr_w-1:0]];
    else
      return '0;
  endfunction

  always_comb begin
    w_rs1_data = rf_read(w_rs1);
    w_rs2_data = rf_read(w_rs2);
  end

  always_comb begin
    w_imm_type  = c_imm_x;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_illegal   = 1'b0;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    case (w_opcode)
      c_op_load: begin
        w_imm_type  = c_imm_i;
        w_mem_read  = 1'b1;
        w_reg_write = 1'b1;
        w_uses_rs1  = 1'b1;
      end
      c_op_imm, c_op_jalr: begin
        w_imm_type  = c_imm_i;
        w_reg_write = 1'b1;
        w_uses_rs1  = 1'b1;
      end
      c_op_store: begin
        w_imm_type  = c_imm_s;
        w_mem_write = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      c_op_branch: begin
        w_imm_type = c_imm_sb;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      c_op_lui, c_op_auipc: begin
        w_imm_type  = c_imm_u;
        w_reg_write = 1'b1;
      end
      c_op_jal: begin
        w_imm_type  = c_imm_uj;
        w_reg_write = 1'b1;
      end
      c_op_op: begin
        w_reg_write = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_rd == 5'd0) w_reg_write = 1'b0;
  end

  always_comb begin
    w_imm32 = 32'd0;
    case (w_imm_type)
      c_imm_i:  w_imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
      c_imm_s:  w_imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      c_imm_sb: w_imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                           if_inst[30:25], if_inst[11:8], 1'b0};
      c_imm_u:  w_imm32 = {if_inst[31:12], 12'd0};
      c_imm_uj: w_imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                           if_inst[20], if_inst[30:21], 1'b0};
      default:  w_imm32 = 32'd0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_imm_sext
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_native
      assign w_imm = w_imm32;
    end
  endgenerate

  // Only a load already in EX can create a dependency that bypass cannot cover.
  assign w_hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & if_valid &
                    ((w_uses_rs1 & (w_rs1 == ex_rd)) | (w_uses_rs2 & (w_rs2 == ex_rd)));
  assign id_stall = w_hazard | ex_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_imm_type  <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush || (!ex_stall && w_hazard)) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid     <= if_valid;
      ex_pc        <= if_pc;
      ex_rs1_data  <= w_rs1_data;
      ex_rs2_data  <= w_rs2_data;
      ex_imm       <= w_imm;
      ex_rs1       <= w_rs1;
      ex_rs2       <= w_rs2;
      ex_rd        <= w_rd;
      ex_opcode    <= w_opcode;
      ex_funct3    <= if_inst[14:12];
      ex_funct7b5  <= if_inst[30];
      ex_imm_type  <= w_imm_type;
      ex_reg_write <= if_valid & w_reg_write;
      ex_mem_read  <= if_valid & w_mem_read;
      ex_mem_write <= if_valid & w_mem_write;
      ex_illegal   <= if_valid & w_illegal;
    end
  end

endmodule
`default_nettype wire
